// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory block: default geometry and the
// bring-up sequencer state encoding.
package program_memory_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 32;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT_COUNT,
    LOAD_HI,
    LOAD_LO,
    RUN,
    HALT
  } state_t;

  // States in which the loader port may transfer a byte.
  function automatic logic is_loading(state_t s);
    return (s == WAIT_COUNT) || (s == LOAD_HI) || (s == LOAD_LO);
  endfunction

endpackage

// File: rtl/program_memory_if.sv
// Bundle of the core memory bus, loader stream, run control and dump port.
// The slave modport is the program memory; the master modport is the
// core/loader/inspection side.
interface program_memory_if
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_read_data;

  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_ready;
  logic                  load_done;

  logic                  execute;
  logic                  halted;

  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_valid;

  modport slave (
    input  mem_addr, mem_write_data, mem_write,
    output mem_read_data,
    input  load_valid, load_byte,
    output load_ready, load_done,
    output execute,
    input  halted,
    input  dump_addr,
    output dump_data, dump_valid
  );

  modport master (
    output mem_addr, mem_write_data, mem_write,
    input  mem_read_data,
    output load_valid, load_byte,
    input  load_ready, load_done,
    input  execute,
    output halted,
    output dump_addr,
    input  dump_data, dump_valid
  );

endinterface

// File: rtl/program_memory_array.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous
// read port for the core, one registered read port for result dumping.
module program_memory_array
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  dump_en,
  input  logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: one word per edge when enabled.
  // NOTE: the array has no reset term; the CLEAR sweep zeroes it, keeping it mappable to RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Core read port: combinational, old word visible until the write edge.
  assign rd_data = mem[rd_addr];

  // Dump read port: registered, refreshed every enabled cycle.
  always_ff @(posedge clock) begin
    if (reset)        dump_data <= '0;
    else if (dump_en) dump_data <= mem[dump_addr];
  end

endmodule

// File: rtl/program_memory.sv
// Program memory responder: clears the array after reset, loads a byte-stream
// image (count byte then high/low byte pairs), runs the core, and exposes a
// dump port once the core halts.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic clock,
  input  logic reset,
  program_memory_if.slave bus
);

  // One extra bit so a count of DEPTH words is representable without wrap.
  localparam int              PW        = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   LAST_WORD = PW'(DEPTH - 1);

  state_t                state, next_state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         count;
  logic [PW-1:0]         count_sat;
  logic [7:0]            hi_q;
  logic                  accept;

  logic                  load_ready_q, load_done_q, execute_q, dump_valid_q;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] dump_data;

  assign accept    = bus.load_valid && load_ready_q;
  assign count_sat = (int'(bus.load_byte) > DEPTH) ? PW'(DEPTH) : PW'(bus.load_byte);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  // Next-state decode.
  // NOTE: next_state takes its default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:      if (ptr == LAST_WORD) next_state = WAIT_COUNT;
      WAIT_COUNT: if (accept) next_state = (count_sat == '0) ? RUN : LOAD_HI;
      LOAD_HI:    if (accept) next_state = LOAD_LO;
      LOAD_LO:    if (accept) next_state = (ptr == count - PW'(1)) ? RUN : LOAD_HI;
      RUN:        if (bus.halted) next_state = HALT;
      HALT:       next_state = HALT;
      default:    next_state = CLEAR;
    endcase
  end

  // Write-port mux: sweep, loader word, or core store (RUN only).
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = ptr[ADDR_WIDTH-1:0];
      end
      LOAD_LO: begin
        wr_en   = accept;
        wr_addr = ptr[ADDR_WIDTH-1:0];
        wr_data = DATA_WIDTH'({hi_q, bus.load_byte});
      end
      RUN: begin
        wr_en   = bus.mem_write;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_write_data;
      end
      default: ;
    endcase
  end

  // Pointers, byte assembly and registered decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr          <= '0;
      count        <= '0;
      hi_q         <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      execute_q    <= 1'b0;
      dump_valid_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: ptr <= ptr + PW'(1);
        WAIT_COUNT: if (accept) begin
          count <= count_sat;
          ptr   <= '0;
        end
        LOAD_HI: if (accept) hi_q <= bus.load_byte;
        LOAD_LO: if (accept) ptr <= ptr + PW'(1);
        default: ;
      endcase
      load_ready_q <= is_loading(next_state);
      execute_q    <= (next_state == RUN);
      dump_valid_q <= (next_state == HALT);
      load_done_q  <= load_done_q || (next_state == RUN);
    end
  end

  program_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (bus.mem_addr),
    .rd_data   (rd_data),
    .dump_en   (state == HALT),
    .dump_addr (bus.dump_addr),
    .dump_data (dump_data)
  );

  assign bus.mem_read_data = rd_data;
  assign bus.dump_data     = dump_data;
  assign bus.load_ready    = load_ready_q;
  assign bus.load_done     = load_done_q;
  assign bus.execute       = execute_q;
  assign bus.dump_valid    = dump_valid_q;

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: randomized images and core traffic
// compared against a word-level model of the expected memory contents.
module tb_program_memory;
  import program_memory_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  program_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  program_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_mem [DEPTH];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    bus.mem_write      = 1'b0;
    bus.load_valid     = 1'b0;
    bus.load_byte      = '0;
    bus.halted         = 1'b0;
    bus.dump_addr      = '0;
  endtask

  // Reference: after reset the whole store is zero.
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  // Reference: image = count byte, then count pairs (hi, lo); count saturates at DEPTH.
  task automatic model_load(input logic [7:0] s[$]);
    int n;
    model_clear();
    n = (int'(s[0]) > DEPTH) ? DEPTH : int'(s[0]);
    for (int i = 0; i < n; i++) exp_mem[i] = {s[1 + 2 * i], s[2 + 2 * i]};
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.load_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Offer one byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.load_valid = 1'b0;
    repeat (gap) tick();
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    while (!bus.load_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.load_ready) begin
      errors++;
      $display("FAIL send_byte_timeout: load_ready=%0b required 1 within 200 cycles", bus.load_ready);
    end
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    int  cycles = 0;
    logic bad_out = 1'b0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.load_ready, bus.load_done, bus.execute, bus.dump_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000",
               {bus.load_ready, bus.load_done, bus.execute, bus.dump_valid});
    end
    checks++;
    if (bus.dump_data !== '0) begin
      errors++;
      $display("FAIL reset_dump_data: got %h required 0000", bus.dump_data);
    end
    reset = 1'b0;
    model_clear();
    while (!bus.load_ready && cycles < 200) begin
      tick();
      cycles++;
      if (bus.execute || bus.dump_valid || bus.load_done) bad_out = 1'b1;
    end
    checks++;
    if (cycles !== 32) begin
      errors++;
      $display("FAIL clear_length: load_ready after %0d cycles required 32", cycles);
    end
    checks++;
    if (bad_out !== 1'b0) begin
      errors++;
      $display("FAIL clear_outputs: execute/dump_valid/load_done seen %0b required 0", bad_out);
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.mem_addr = AW'(a);
      #1;
      checks++;
      if (bus.mem_read_data !== 16'h0000) begin
        errors++;
        $display("FAIL clear_word[%0d]: got %h required 0000", a, bus.mem_read_data);
      end
    end
  endtask

  task automatic test_load_basic();
    logic [7:0] s[$] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    apply_reset();
    wait_ready();
    model_load(s);
    for (int i = 0; i < 4; i++) send_byte(s[i], 1);
    tick();
    bus.load_valid = 1'b1;
    bus.load_byte  = s[4];
    checks++;
    if (bus.execute !== 1'b0 || bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL before_last_byte: execute=%0b load_ready=%0b required 0/1",
               bus.execute, bus.load_ready);
    end
    tick();
    bus.load_valid = 1'b0;
    checks++;
    if ({bus.execute, bus.load_done, bus.load_ready} !== 3'b110) begin
      errors++;
      $display("FAIL after_last_byte: execute/load_done/load_ready=%b required 110",
               {bus.execute, bus.load_done, bus.load_ready});
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.mem_addr = AW'(a);
      #1;
      checks++;
      if (bus.mem_read_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL basic_word[%0d]: got %h required %h", a, bus.mem_read_data, exp_mem[a]);
      end
    end
  endtask

  // Runs in RUN state, continuing after test_load_basic.
  task automatic test_core_write();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bus.mem_addr       = 5'd5;
    bus.mem_write_data = 16'hBEEF;
    bus.mem_write      = 1'b1;
    #1;
    checks++;
    if (bus.mem_read_data !== exp_mem[5]) begin
      errors++;
      $display("FAIL rdw_old: got %h required %h", bus.mem_read_data, exp_mem[5]);
    end
    tick();
    bus.mem_write = 1'b0;
    exp_mem[5] = 16'hBEEF;
    checks++;
    if (bus.mem_read_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL rdw_new: got %h required beef", bus.mem_read_data);
    end
    for (int i = 0; i < 12; i++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      d = DW'($urandom);
      bus.mem_addr       = a;
      bus.mem_write_data = d;
      bus.mem_write      = 1'b1;
      tick();
      exp_mem[a] = d;
    end
    bus.mem_write = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.mem_addr = AW'(k);
      #1;
      checks++;
      if (bus.mem_read_data !== exp_mem[k]) begin
        errors++;
        $display("FAIL core_word[%0d]: got %h required %h", k, bus.mem_read_data, exp_mem[k]);
      end
    end
  endtask

  task automatic test_write_ignored();
    logic [7:0] s[$] = '{8'h03};
    for (int i = 0; i < 6; i++) s.push_back(8'($urandom));
    apply_reset();
    wait_ready();
    model_load(s);
    bus.mem_addr       = 5'd5;
    bus.mem_write_data = 16'hBEEF;
    bus.mem_write      = 1'b1;
    tick();
    bus.mem_write = 1'b0;
    checks++;
    if (bus.mem_read_data !== 16'h0000) begin
      errors++;
      $display("FAIL wait_write_ignored: got %h required 0000", bus.mem_read_data);
    end
    bus.mem_addr       = 5'd7;
    bus.mem_write_data = 16'h5A5A;
    bus.mem_write      = 1'b1;
    send_byte(s[0], 0);
    send_byte(s[1], 0);
    send_byte(s[2], 0);
    bus.mem_write = 1'b0;
    for (int i = 3; i < 7; i++) send_byte(s[i], 0);
    for (int a = 0; a < DEPTH; a++) begin
      bus.mem_addr = AW'(a);
      #1;
      checks++;
      if (bus.mem_read_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL load_write_ignored[%0d]: got %h required %h", a, bus.mem_read_data, exp_mem[a]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] s[$] = '{8'h40};
    logic       ready_seen = 1'b0;
    for (int i = 0; i < 128; i++) s.push_back(8'($urandom));
    apply_reset();
    wait_ready();
    model_load(s);
    for (int i = 0; i < 64; i++) send_byte(s[i], $urandom_range(0, 1));
    bus.load_valid = 1'b1;
    bus.load_byte  = s[64];
    checks++;
    if (bus.execute !== 1'b0) begin
      errors++;
      $display("FAIL sat_before_last: execute=%0b required 0", bus.execute);
    end
    tick();
    checks++;
    if (bus.execute !== 1'b1 || bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_after_word31: execute=%0b load_ready=%0b required 1/0",
               bus.execute, bus.load_ready);
    end
    for (int i = 65; i < 129; i++) begin
      bus.load_byte = s[i];
      tick();
      if (bus.load_ready) ready_seen = 1'b1;
    end
    bus.load_valid = 1'b0;
    checks++;
    if (ready_seen !== 1'b0) begin
      errors++;
      $display("FAIL sat_extra_ready: load_ready seen %0b required 0", ready_seen);
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.mem_addr = AW'(a);
      #1;
      checks++;
      if (bus.mem_read_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL sat_word[%0d]: got %h required %h", a, bus.mem_read_data, exp_mem[a]);
      end
    end
  endtask

  task automatic test_random_load();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] s[$];
      int n = $urandom_range(1, DEPTH - 1);
      s.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
      apply_reset();
      wait_ready();
      model_load(s);
      foreach (s[i]) send_byte(s[i], $urandom_range(0, 2));
      checks++;
      if (bus.execute !== 1'b1 || bus.load_done !== 1'b1) begin
        errors++;
        $display("FAIL rand_run[%0d]: execute=%0b load_done=%0b required 1/1",
                 it, bus.execute, bus.load_done);
      end
      for (int a = 0; a < DEPTH; a++) begin
        bus.mem_addr = AW'(a);
        #1;
        checks++;
        if (bus.mem_read_data !== exp_mem[a]) begin
          errors++;
          $display("FAIL rand_word[%0d][%0d]: got %h required %h", it, a, bus.mem_read_data, exp_mem[a]);
        end
      end
    end
  endtask

  task automatic test_zero_halt();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    apply_reset();
    wait_ready();
    send_byte(8'h00, 0);
    checks++;
    if ({bus.execute, bus.load_done, bus.load_ready} !== 3'b110) begin
      errors++;
      $display("FAIL zero_count_run: execute/load_done/load_ready=%b required 110",
               {bus.execute, bus.load_done, bus.load_ready});
    end
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 5'd3 : AW'($urandom_range(0, DEPTH - 1));
      d = DW'($urandom);
      bus.mem_addr       = a;
      bus.mem_write_data = d;
      bus.mem_write      = 1'b1;
      tick();
      exp_mem[a] = d;
    end
    bus.mem_write = 1'b0;
    bus.halted    = 1'b1;
    tick();
    bus.halted = 1'b0;
    checks++;
    if (bus.execute !== 1'b0 || bus.dump_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_flags: execute=%0b dump_valid=%0b required 0/1", bus.execute, bus.dump_valid);
    end
    bus.mem_addr       = 5'd3;
    bus.mem_write_data = ~exp_mem[3];
    bus.mem_write      = 1'b1;
    tick();
    bus.mem_write = 1'b0;
    checks++;
    if (bus.mem_read_data !== exp_mem[3]) begin
      errors++;
      $display("FAIL halt_write_ignored: got %h required %h", bus.mem_read_data, exp_mem[3]);
    end
    for (int i = 0; i < 10; i++) begin
      a = (i == 0) ? 5'd3 : AW'($urandom_range(0, DEPTH - 1));
      bus.dump_addr = a;
      tick();
      checks++;
      if (bus.dump_data !== exp_mem[a] || bus.dump_valid !== 1'b1) begin
        errors++;
        $display("FAIL dump[%0d]: got %h valid %0b required %h valid 1",
                 a, bus.dump_data, bus.dump_valid, exp_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int   cycles = 0;
    logic exec_seen = 1'b0;
    logic [7:0] s[$] = '{8'h0A};
    for (int i = 0; i < 7; i++) s.push_back(8'($urandom_range(1, 255)));
    apply_reset();
    wait_ready();
    foreach (s[i]) send_byte(s[i], 0);
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.execute, bus.load_ready, bus.load_done} !== 3'b000) begin
      errors++;
      $display("FAIL midload_reset_flags: got %b required 000",
               {bus.execute, bus.load_ready, bus.load_done});
    end
    reset = 1'b0;
    model_clear();
    while (!bus.load_ready && cycles < 200) begin
      tick();
      cycles++;
      if (bus.execute) exec_seen = 1'b1;
    end
    checks++;
    if (cycles !== 32 || exec_seen !== 1'b0) begin
      errors++;
      $display("FAIL midload_reclear: %0d cycles execute_seen=%0b required 32/0", cycles, exec_seen);
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.mem_addr = AW'(a);
      #1;
      checks++;
      if (bus.mem_read_data !== exp_mem[a]) begin
        errors++;
        $display("FAIL midload_word[%0d]: got %h required %h", a, bus.mem_read_data, exp_mem[a]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_basic();
    test_core_write();
    test_write_ignored();
    test_saturate();
    test_random_load();
    test_zero_halt();
    test_reset();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
